// File: rtl/uart_dma_apb_master.sv
// uart_dma_apb_master: DMA-style APB master that feeds an APB UART.
// Outgoing bytes are buffered in a small TX FIFO and written to the UART TX data
// register on dma_tx_req. On dma_rx_req the UART RX data register is read and the
// byte is presented on a local valid/ready stream. Both DMA handshakes are closed
// with a 4-phase acknowledge.
// Optional feature macro: UART_DMA_TIMEOUT_EN. When defined, an ACCESS phase
// that sees no pready within TIMEOUT cycles is aborted and flagged in err.
module uart_dma_apb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'hC3000000,
  parameter logic [31:0] TX_OFFSET  = 32'h44,
  parameter logic [31:0] RX_OFFSET  = 32'h34,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          prst,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [31:0]                   paddr,
  output logic [31:0]                   pwdata,
  output logic [3:0]                    pstrb,
  output logic [2:0]                    pprot,
  input  logic                          pready,
  input  logic [31:0]                   prdata,
  input  logic                          pslverr,
  input  logic                          dma_tx_req,
  input  logic                          dma_rx_req,
  output logic                          dma_tx_acka,
  output logic                          dma_rx_acka,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0]   TX_ADDR  = BASE_ADDR + TX_OFFSET;
  localparam logic [31:0]   RX_ADDR  = BASE_ADDR + RX_OFFSET;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ACK} state_t;

  state_t        state;
  logic          dir_tx;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          rx_elig;
  logic          tx_elig;
  logic          in_access;
  logic          timeout_hit;
  logic          xfer_end;
  logic          rx_load;
  logic          err_set;
  logic          unused_prdata;

  // Only the low byte of a UART RX data read carries data.
  assign unused_prdata = ^prdata[31:8];

  assign full     = (tx_level == LVL_FULL);
  assign empty    = (tx_level == '0);
  assign tx_ready = !full;
  assign push     = tx_valid & !full;

  assign rx_elig  = dma_rx_req & !rx_valid;
  assign tx_elig  = dma_tx_req & !empty;

  assign in_access = (state == S_ACCESS);
  assign xfer_end  = in_access & (pready | timeout_hit);
  // A TX byte leaves the FIFO on any completion, including error and abort.
  assign pop       = xfer_end & dir_tx;
  assign rx_load   = in_access & pready & !pslverr & !dir_tx;
  assign err_set   = in_access & ((pready & pslverr) | timeout_hit);

`ifdef UART_DMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(TIMEOUT - 1);
  logic [CW-1:0] to_cnt;

  assign timeout_hit = in_access & !pready & (to_cnt == '0);

  // Down-counter of remaining ACCESS cycles, armed while the transfer is in SETUP.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      to_cnt <= '0;
    end else if (state == S_SETUP) begin
      to_cnt <= CNT_INIT;
    end else if (in_access && to_cnt != '0) begin
      to_cnt <= to_cnt - CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   tx_level <= tx_level + LVL_ONE;
        2'b01:   tx_level <= tx_level - LVL_ONE;
        default: tx_level <= tx_level;
      endcase
    end
  end

  // Transfer sequencer with registered APB and acknowledge outputs.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state       <= S_IDLE;
      dir_tx      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      dma_tx_acka <= 1'b0;
      dma_rx_acka <= 1'b0;
    end else begin
      pprot <= 3'b000;
      case (state)
        S_IDLE: begin
          // RX has priority so the UART receive path cannot overrun.
          if (rx_elig) begin
            state  <= S_SETUP;
            dir_tx <= 1'b0;
            psel   <= 1'b1;
            pwrite <= 1'b0;
            paddr  <= RX_ADDR;
            pwdata <= '0;
            pstrb  <= 4'h0;
          end else if (tx_elig) begin
            state  <= S_SETUP;
            dir_tx <= 1'b1;
            psel   <= 1'b1;
            pwrite <= 1'b1;
            paddr  <= TX_ADDR;
            pwdata <= {24'b0, mem[rd_ptr]};
            pstrb  <= 4'h1;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
        end
        S_ACCESS: begin
          if (xfer_end) begin
            state   <= S_ACK;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            if (dir_tx) begin
              dma_tx_acka <= 1'b1;
            end else begin
              dma_rx_acka <= 1'b1;
            end
          end
        end
        S_ACK: begin
          // Hold the acknowledge until the UART withdraws its request.
          if (dir_tx && !dma_tx_req) begin
            dma_tx_acka <= 1'b0;
            state       <= S_IDLE;
          end else if (!dir_tx && !dma_rx_req) begin
            dma_rx_acka <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RX output stream register: loaded by a clean read, cleared on consumption.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (rx_load) begin
      rx_valid <= 1'b1;
      rx_data  <= prdata[7:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky error flag; a new error outranks a clear in the same cycle.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_dma_apb_master.sv
// Testbench for uart_dma_apb_master: directed scenarios checked against a
// transaction-level model (byte queue plus transfer phase) every cycle, plus
// hand-computed literal expectations.
module tb_uart_dma_apb_master;

  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] TXA     = 32'hC3000044;
  localparam logic [31:0] RXA     = 32'hC3000034;

  logic        pclk = 1'b0;
  logic        prst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        dma_tx_req, dma_rx_req;
  logic        dma_tx_acka, dma_rx_acka;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [3:0]  tx_level;
  logic        err, err_clr;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_dma_apb_master dut (
    .pclk(pclk), .prst(prst),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .dma_tx_req(dma_tx_req), .dma_rx_req(dma_rx_req),
    .dma_tx_acka(dma_tx_acka), .dma_rx_acka(dma_rx_acka),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .err(err), .err_clr(err_clr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Completed APB transfers as seen on the bus.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } xact_t;
  xact_t log_q[$];

  // Transaction-level model. Phase: 0 idle, 1 setup, 2 access, 3 acknowledge.
  logic [7:0] mq[$];
  int         ph = 0;
  logic       m_dir_rx = 1'b0;
  logic [7:0] m_cur = '0;
  int         m_acc = 0;
  logic       m_rxv = 1'b0;
  logic [7:0] m_rxd = '0;
  logic       m_err = 1'b0;

  task automatic model_step();
    logic old_rxv, push_ok, do_pop, err_set;
    if (prst) begin
      mq.delete();
      ph = 0; m_rxv = 1'b0; m_err = 1'b0; m_acc = 0;
    end else begin
      old_rxv = m_rxv;
      push_ok = tx_valid && (mq.size() < DEPTH);
      do_pop  = 1'b0;
      err_set = 1'b0;
      case (ph)
        0: begin
          if (dma_rx_req && !old_rxv) begin
            ph = 1; m_dir_rx = 1'b1;
          end else if (dma_tx_req && mq.size() > 0) begin
            ph = 1; m_dir_rx = 1'b0; m_cur = mq[0];
          end
        end
        1: begin ph = 2; m_acc = 0; end
        2: begin
          m_acc++;
          if (pready) begin
            ph = 3;
            if (!m_dir_rx) do_pop = 1'b1;
            else if (!pslverr) begin m_rxv = 1'b1; m_rxd = prdata[7:0]; end
            if (pslverr) err_set = 1'b1;
          end
`ifdef UART_DMA_TIMEOUT_EN
          else if (m_acc >= TIMEOUT) begin
            ph = 3;
            if (!m_dir_rx) do_pop = 1'b1;
            err_set = 1'b1;
          end
`endif
        end
        default: begin
          if (!(m_dir_rx ? dma_rx_req : dma_tx_req)) ph = 0;
        end
      endcase
      if (old_rxv && rx_ready) m_rxv = 1'b0;
      if (err_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (push_ok) mq.push_back(tx_data);
    end
  endtask

  // Single compare process: log completions, advance the model, then check outputs.
  always begin
    @(posedge pclk);
    if (!prst && psel === 1'b1 && penable === 1'b1 && pready === 1'b1)
      log_q.push_back('{wr: pwrite, addr: paddr, data: pwdata, strb: pstrb});
    model_step();
    #1;
    chk("psel", psel, (ph == 1 || ph == 2));
    chk("penable", penable, (ph == 2));
    chk("pprot", pprot, 0);
    if (ph == 1 || ph == 2) begin
      chk("paddr", paddr, m_dir_rx ? RXA : TXA);
      chk("pwrite", pwrite, !m_dir_rx);
      chk("pwdata", pwdata, m_dir_rx ? 32'h0 : {24'h0, m_cur});
      chk("pstrb", pstrb, m_dir_rx ? 4'h0 : 4'h1);
    end
    chk("dma_tx_acka", dma_tx_acka, (ph == 3 && !m_dir_rx));
    chk("dma_rx_acka", dma_rx_acka, (ph == 3 && m_dir_rx));
    chk("rx_valid", rx_valid, m_rxv);
    if (m_rxv) chk("rx_data", rx_data, m_rxd);
    chk("err", err, m_err);
    chk("tx_level", tx_level, mq.size());
    chk("tx_ready", tx_ready, (mq.size() < DEPTH));
  end

  function automatic logic sig_sel(input int which);
    case (which)
      0: return dma_tx_acka;
      1: return dma_rx_acka;
      default: return psel;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string name);
    int n = 0;
    while (sig_sel(which) !== val && n < 100) begin
      @(negedge pclk);
      n++;
    end
    total_cnt++;
    if (sig_sel(which) === val) pass_cnt++;
    else $display("FAIL %s: timed out after %0d cycles, value %b, wanted %b", name, n, sig_sel(which), val);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge pclk);
    tx_valid = 1'b1; tx_data = b;
    @(negedge pclk);
    tx_valid = 1'b0;
  endtask

  task automatic tx_service();
    @(negedge pclk);
    dma_tx_req = 1'b1;
    wait_for(0, 1'b1, "tx_acka_rise");
    @(negedge pclk);
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "tx_acka_fall");
  endtask

  task automatic consume_rx();
    @(negedge pclk); rx_ready = 1'b1;
    @(negedge pclk); rx_ready = 1'b0;
  endtask

  initial begin
    prst = 1'b1; pready = 1'b1; prdata = '0; pslverr = 1'b0;
    dma_tx_req = 1'b0; dma_rx_req = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_psel", psel, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_tx_level", tx_level, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_err", err, 0);
    chk("reset_paddr", paddr, 0);
    prst = 1'b0;

    // Single TX write of 0x89.
    log_q.delete();
    push_byte(8'h89);
    chk("tx1_level_before", tx_level, 1);
    @(negedge pclk);
    dma_tx_req = 1'b1;
    wait_for(0, 1'b1, "tx1_acka_rise");
    chk("tx1_level_after", tx_level, 0);
    repeat (3) @(negedge pclk);
    chk("tx1_acka_held", dma_tx_acka, 1);
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "tx1_acka_fall");
    chk("tx1_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("tx1_addr", log_q[0].addr, 32'hC3000044);
      chk("tx1_data", log_q[0].data, 32'h00000089);
      chk("tx1_strb", log_q[0].strb, 4'h1);
      chk("tx1_wr", log_q[0].wr, 1);
    end

    // Single RX read of 0xA5.
    log_q.delete();
    prdata = 32'h000000A5;
    @(negedge pclk);
    dma_rx_req = 1'b1;
    wait_for(1, 1'b1, "rx1_acka_rise");
    chk("rx1_data", rx_data, 8'hA5);
    chk("rx1_valid", rx_valid, 1);
    @(negedge pclk);
    dma_rx_req = 1'b0;
    wait_for(1, 1'b0, "rx1_acka_fall");
    repeat (3) @(negedge pclk);
    chk("rx1_valid_held", rx_valid, 1);
    consume_rx();
    chk("rx1_valid_cleared", rx_valid, 0);
    chk("rx1_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("rx1_addr", log_q[0].addr, 32'hC3000034);
      chk("rx1_wr", log_q[0].wr, 0);
    end

    // Arbitration: both requests with rx_valid=0, RX goes first.
    log_q.delete();
    prdata = 32'hDEADBEC3;
    push_byte(8'h11);
    @(negedge pclk);
    dma_rx_req = 1'b1; dma_tx_req = 1'b1;
    wait_for(1, 1'b1, "arb_rx_acka_rise");
    chk("arb_first_is_read", (log_q.size() == 1) ? log_q[0].wr : 1'bx, 0);
    repeat (2) @(negedge pclk);
    chk("arb_tx_waits", psel, 0);
    dma_rx_req = 1'b0;
    wait_for(1, 1'b0, "arb_rx_acka_fall");
    wait_for(0, 1'b1, "arb_tx_acka_rise");
    chk("arb_second_data", (log_q.size() == 2) ? log_q[1].data : 32'hx, 32'h00000011);
    chk("arb_rx_byte", rx_data, 8'hC3);
    @(negedge pclk);
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "arb_tx_acka_fall");

    // Arbitration with rx_valid=1: TX goes first.
    log_q.delete();
    prdata = 32'h0000005C;
    push_byte(8'h22);
    @(negedge pclk);
    dma_rx_req = 1'b1; dma_tx_req = 1'b1;
    wait_for(0, 1'b1, "arb2_tx_acka_rise");
    chk("arb2_first_is_write", (log_q.size() == 1) ? log_q[0].data : 32'hx, 32'h00000022);
    chk("arb2_rx_not_acked", dma_rx_acka, 0);
    @(negedge pclk);
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "arb2_tx_acka_fall");
    consume_rx();
    wait_for(1, 1'b1, "arb2_rx_acka_rise");
    chk("arb2_rx_byte", rx_data, 8'h5C);
    @(negedge pclk);
    dma_rx_req = 1'b0;
    wait_for(1, 1'b0, "arb2_rx_acka_fall");
    consume_rx();

    // FIFO full: 0x01..0x08 accepted, 0x09 dropped.
    log_q.delete();
    @(negedge pclk);
    tx_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tx_data = 8'(i);
      @(negedge pclk);
    end
    tx_valid = 1'b0;
    chk("full_level", tx_level, 8);
    chk("full_tx_ready", tx_ready, 0);
    for (int i = 0; i < 8; i++) tx_service();
    chk("full_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk("full_order", log_q[i].data, 32'(i + 1));
    chk("full_drained", tx_level, 0);

    // Slave error on a TX write of 0x5A.
    push_byte(8'h5A);
    pslverr = 1'b1;
    @(negedge pclk);
    dma_tx_req = 1'b1;
    wait_for(0, 1'b1, "slverr_acka_rise");
    chk("slverr_err", err, 1);
    chk("slverr_popped", tx_level, 0);
    pslverr = 1'b0;
    @(negedge pclk);
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "slverr_acka_fall");
    @(negedge pclk); err_clr = 1'b1;
    @(negedge pclk); err_clr = 1'b0;
    chk("slverr_cleared", err, 0);

    // Stalled slave.
    push_byte(8'h33);
    pready = 1'b0;
    @(negedge pclk);
    dma_tx_req = 1'b1;
    repeat (20) @(negedge pclk);
`ifdef UART_DMA_TIMEOUT_EN
    chk("timeout_err", err, 1);
    chk("timeout_acka", dma_tx_acka, 1);
    chk("timeout_popped", tx_level, 0);
    pready = 1'b1;
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "timeout_acka_fall");
    @(negedge pclk); err_clr = 1'b1;
    @(negedge pclk); err_clr = 1'b0;
`else
    chk("stall_psel", psel, 1);
    chk("stall_penable", penable, 1);
    chk("stall_err", err, 0);
    pready = 1'b1;
    wait_for(0, 1'b1, "stall_acka_rise");
    @(negedge pclk);
    dma_tx_req = 1'b0;
    wait_for(0, 1'b0, "stall_acka_fall");
`endif

    // Reset in the middle of a transfer.
    push_byte(8'h44);
    push_byte(8'h55);
    pready = 1'b0;
    @(negedge pclk);
    dma_tx_req = 1'b1;
    wait_for(2, 1'b1, "rst_psel_rise");
    @(negedge pclk);
    #2 prst = 1'b1;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_level", tx_level, 0);
    chk("rst_mid_tx_ready", tx_ready, 1);
    @(negedge pclk);
    prst = 1'b0; dma_tx_req = 1'b0; pready = 1'b1;
    repeat (4) @(negedge pclk);
    chk("rst_mid_idle", psel, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
